// File: rtl/weight_tile_s2p.sv
// Serial-to-parallel weight tile builder: collects S2P*S2P RAM beats into one of two
// ping-pong banks and presents completed tiles to a consumer with ready/valid.
module weight_tile_s2p #(
    parameter int S2P = 8,
    parameter int DW  = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_clear,
    input  logic                    i_addr_valid,
    input  logic                    i_padding_valid,
    input  logic [DW-1:0]           i_rd_data,
    output logic                    o_stall,
    output logic [S2P*S2P*DW-1:0]   o_tile_data,
    output logic                    o_tile_valid,
    input  logic                    i_tile_ready,
    output logic                    o_overflow
);

    localparam int N    = S2P * S2P;
    localparam int CW   = (S2P > 1) ? $clog2(S2P) : 1;
    localparam int CNTW = $clog2(N) + 1;
    localparam int TW   = N * DW;

    logic            beat_v_q, beat_v_d;
    logic            beat_pad_q, beat_pad_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CNTW-1:0] fill_cnt_q, fill_cnt_d;
    logic            fill_ptr_q, fill_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      full_q, full_d;
    logic            overflow_q, overflow_d;
    logic [TW-1:0]   bank_q [2];
    logic [TW-1:0]   bank_d [2];

    logic [DW-1:0]   beat_data;
    logic            last_beat;
    logic            handshake;
    logic [1:0]      pending;
    logic [CNTW:0]   need;
    int              wr_idx;

    always_comb begin
        beat_v_d   = i_addr_valid;
        beat_pad_d = i_padding_valid;
        row_d      = row_q;
        col_d      = col_q;
        fill_cnt_d = fill_cnt_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        bank_d     = bank_q;

        beat_data = beat_pad_q ? '0 : i_rd_data;
        wr_idx    = S2P * int'(row_q) + int'(col_q);
        last_beat = (row_q == CW'(S2P - 1)) && (col_q == CW'(S2P - 1));
        handshake = full_q[rd_ptr_q] && i_tile_ready;

        if (i_clear) begin
            beat_v_d   = 1'b0;
            beat_pad_d = 1'b0;
            row_d      = '0;
            col_d      = '0;
            fill_cnt_d = '0;
            fill_ptr_d = 1'b0;
            rd_ptr_d   = 1'b0;
            full_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (handshake) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
            end
            // Completion and release always hit different banks: a bank being
            // written is never full, and release needs a full bank.
            if (beat_v_q) begin
                if (full_q[fill_ptr_q]) begin
                    overflow_d = 1'b1;
                end else begin
                    bank_d[fill_ptr_q][wr_idx*DW +: DW] = beat_data;
                    if (last_beat) begin
                        full_d[fill_ptr_q] = 1'b1;
                        fill_ptr_d         = ~fill_ptr_q;
                        row_d              = '0;
                        col_d              = '0;
                        fill_cnt_d         = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + CNTW'(1);
                        if (col_q == CW'(S2P - 1)) begin
                            col_d = '0;
                            row_d = row_q + CW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
        end
    end

    // In-flight beats (registered beat plus this cycle's address) are already
    // committed, so stall must leave room for them. Once both banks hold tiles
    // the fill counter has wrapped to zero, so that case stalls on its own.
    always_comb begin
        pending = {1'b0, i_addr_valid} + {1'b0, beat_v_q};
        need    = (CNTW+1)'(fill_cnt_q) + (CNTW+1)'(pending);
        o_stall = (full_q[~fill_ptr_q] && (need >= (CNTW+1)'(N))) || full_q[fill_ptr_q];
    end

    assign o_tile_valid = full_q[rd_ptr_q];
    assign o_tile_data  = bank_q[rd_ptr_q];
    assign o_overflow   = overflow_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_v_q   <= 1'b0;
            beat_pad_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            fill_cnt_q <= '0;
            fill_ptr_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            full_q     <= '0;
            overflow_q <= 1'b0;
            bank_q[0]  <= '0;
            bank_q[1]  <= '0;
        end else begin
            beat_v_q   <= beat_v_d;
            beat_pad_q <= beat_pad_d;
            row_q      <= row_d;
            col_q      <= col_d;
            fill_cnt_q <= fill_cnt_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
        end
    end

endmodule
